sum4bit_checker: RTL and testbench

SUM4BIT_CHECKER -- requirements
Module: sum4bit_checker

---
 rtl/sum4bit_checker.sv | 202 ++++++++++++++++++++
 tb/tb_sum4bit_checker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum4bit_checker.sv
// -----------------------------------------------------------------------------
// sum4bit_checker
//
// Checks the result of a 4-bit adder. A triple (x0, x1, o) is captured when
// the block is idle, the expected 5-bit sum is rebuilt bit-serially with a
// single full adder (one bit per clock), and then compared with the captured
// o. Pass/fail counts saturate at 255. The first mismatching triple since
// reset or clr is held for inspection.
//
// Timing: accept at edge T0, sum bits 0..3 at T1..T4 (carry-out becomes bit 4
// at T4), compare at T5. done_valid is high for the cycle after T5, and the
// next triple can be accepted at T6.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  triple presented for checking
//   in_ready   out  1  block is idle and will accept a triple
//   x0, x1     in   4  addends driven to the adder under check
//   o          in   5  adder result to be checked
//   clr        in   1  synchronous clear of counters and fail capture
//   done_valid out  1  one-cycle pulse: check result available
//   match      out  1  last check result (1 = o equals x0+x1), held
//   pass_cnt   out  8  saturating count of matching checks
//   fail_cnt   out  8  saturating count of mismatching checks
//   fail_seen  out  1  sticky: a mismatch occurred since reset/clr
//   ff_x0/ff_x1/ff_o out 4/4/5  triple of the first mismatch
// -----------------------------------------------------------------------------
module sum4bit_checker (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] x0,
   input  logic [3:0] x1,
   input  logic [4:0] o,
   input  logic       clr,
   output logic       done_valid,
   output logic       match,
   output logic [7:0] pass_cnt,
   output logic [7:0] fail_cnt,
   output logic       fail_seen,
   output logic [3:0] ff_x0,
   output logic [3:0] ff_x1,
   output logic [4:0] ff_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      CMP  = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] x0_q, x0_d;
   logic [3:0] x1_q, x1_d;
   logic [4:0] o_q, o_d;
   logic       carry_q, carry_d;
   logic [1:0] idx_q, idx_d;
   logic [4:0] exp_q, exp_d;
   logic       done_q, done_d;
   logic       match_q, match_d;
   logic [7:0] pass_cnt_q, pass_cnt_d;
   logic [7:0] fail_cnt_q, fail_cnt_d;
   logic       fail_seen_q, fail_seen_d;
   logic [3:0] ff_x0_q, ff_x0_d;
   logic [3:0] ff_x1_q, ff_x1_d;
   logic [4:0] ff_o_q, ff_o_d;

   // Single full adder shared across the four bit positions.
   logic bit_a, bit_b, bit_sum, bit_carry;
   assign bit_a     = x0_q[idx_q];
   assign bit_b     = x1_q[idx_q];
   assign bit_sum   = bit_a ^ bit_b ^ carry_q;
   assign bit_carry = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);

   logic is_match;
   assign is_match = (exp_q == o_q);

   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the
      // case below can leave one unassigned and infer a latch.
      state_d     = state_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      o_d         = o_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      exp_d       = exp_q;
      done_d      = 1'b0;
      match_d     = match_q;
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      fail_seen_d = fail_seen_q;
      ff_x0_d     = ff_x0_q;
      ff_x1_d     = ff_x1_q;
      ff_o_d      = ff_o_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x0_d    = x0;
               x1_d    = x1;
               o_d     = o;
               carry_d = 1'b0;
               idx_d   = 2'd0;
               exp_d   = 5'd0;
               state_d = CALC;
            end
         end

         CALC: begin
            exp_d[idx_q] = bit_sum;
            carry_d      = bit_carry;
            idx_d        = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               // Carry out of bit 3 is the fifth sum bit: no modulo wrap.
               exp_d[4] = bit_carry;
               state_d  = CMP;
            end
         end

         CMP: begin
            done_d  = 1'b1;
            match_d = is_match;
            if (is_match) begin
               if (pass_cnt_q != 8'hFF) pass_cnt_d = pass_cnt_q + 8'd1;
            end else begin
               if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
               if (!fail_seen_q) begin
                  fail_seen_d = 1'b1;
                  ff_x0_d     = x0_q;
                  ff_x1_d     = x1_q;
                  ff_o_d      = o_q;
               end
            end
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // clr wins over a coinciding compare; the FSM keeps running.
      if (clr) begin
         pass_cnt_d  = 8'd0;
         fail_cnt_d  = 8'd0;
         fail_seen_d = 1'b0;
         ff_x0_d     = 4'd0;
         ff_x1_d     = 4'd0;
         ff_o_d      = 5'd0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         x0_q        <= 4'd0;
         x1_q        <= 4'd0;
         o_q         <= 5'd0;
         carry_q     <= 1'b0;
         idx_q       <= 2'd0;
         exp_q       <= 5'd0;
         done_q      <= 1'b0;
         match_q     <= 1'b0;
         pass_cnt_q  <= 8'd0;
         fail_cnt_q  <= 8'd0;
         fail_seen_q <= 1'b0;
         ff_x0_q     <= 4'd0;
         ff_x1_q     <= 4'd0;
         ff_o_q      <= 5'd0;
      end else begin
         state_q     <= state_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         o_q         <= o_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         exp_q       <= exp_d;
         done_q      <= done_d;
         match_q     <= match_d;
         pass_cnt_q  <= pass_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         fail_seen_q <= fail_seen_d;
         ff_x0_q     <= ff_x0_d;
         ff_x1_q     <= ff_x1_d;
         ff_o_q      <= ff_o_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign done_valid = done_q;
   assign match      = match_q;
   assign pass_cnt   = pass_cnt_q;
   assign fail_cnt   = fail_cnt_q;
   assign fail_seen  = fail_seen_q;
   assign ff_x0      = ff_x0_q;
   assign ff_x1      = ff_x1_q;
   assign ff_o       = ff_o_q;

endmodule

// File: tb/tb_sum4bit_checker.sv
// -----------------------------------------------------------------------------
// tb_sum4bit_checker
//
// Self-checking bench for sum4bit_checker. Expected results come from a
// behavioural model using plain integer addition, saturating counters and a
// first-failure capture, plus a cycle counter for accept/done timing.
// -----------------------------------------------------------------------------
module tb_sum4bit_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] x0;
   logic [3:0] x1;
   logic [4:0] o;
   logic       clr;
   logic       done_valid;
   logic       match;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;
   logic       fail_seen;
   logic [3:0] ff_x0;
   logic [3:0] ff_x1;
   logic [4:0] ff_o;

   sum4bit_checker dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x0         (x0),
      .x1         (x1),
      .o          (o),
      .clr        (clr),
      .done_valid (done_valid),
      .match      (match),
      .pass_cnt   (pass_cnt),
      .fail_cnt   (fail_cnt),
      .fail_seen  (fail_seen),
      .ff_x0      (ff_x0),
      .ff_x1      (ff_x1),
      .ff_o       (ff_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_pass;
   int         m_fail;
   bit         m_seen;
   logic [3:0] m_f0;
   logic [3:0] m_f1;
   logic [4:0] m_fo;

   task automatic model_clear();
      m_pass = 0;
      m_fail = 0;
      m_seen = 1'b0;
      m_f0   = 4'd0;
      m_f1   = 4'd0;
      m_fo   = 5'd0;
   endtask

   function automatic bit sum_ok(input logic [3:0] a, input logic [3:0] b, input logic [4:0] r);
      return (int'(a) + int'(b)) == int'(r);
   endfunction

   task automatic model_done(input logic [3:0] a, input logic [3:0] b, input logic [4:0] r,
                             input bit clr_now);
      if (clr_now) begin
         model_clear();
      end else if (sum_ok(a, b, r)) begin
         m_pass = (m_pass < 255) ? m_pass + 1 : 255;
      end else begin
         m_fail = (m_fail < 255) ? m_fail + 1 : 255;
         if (!m_seen) begin
            m_seen = 1'b1;
            m_f0   = a;
            m_f1   = b;
            m_fo   = r;
         end
      end
   endtask

   task automatic check_counters(input string tag);
      check({tag, ".pass_cnt"},  pass_cnt,  m_pass);
      check({tag, ".fail_cnt"},  fail_cnt,  m_fail);
      check({tag, ".fail_seen"}, fail_seen, m_seen);
      check({tag, ".ff_x0"},     ff_x0,     m_f0);
      check({tag, ".ff_x1"},     ff_x1,     m_f1);
      check({tag, ".ff_o"},      ff_o,      m_fo);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".in_ready"},   in_ready,   1);
      check({tag, ".done_valid"}, done_valid, 0);
      check({tag, ".match"},      match,      0);
      check({tag, ".pass_cnt"},   pass_cnt,   0);
      check({tag, ".fail_cnt"},   fail_cnt,   0);
      check({tag, ".fail_seen"},  fail_seen,  0);
      check({tag, ".ff_x0"},      ff_x0,      0);
      check({tag, ".ff_x1"},      ff_x1,      0);
      check({tag, ".ff_o"},       ff_o,       0);
   endtask

   // One full check: present triple, scramble inputs while busy (in_valid
   // randomly toggled too, must be ignored), wait for done with a bound.
   task automatic run_check(input logic [3:0] a, input logic [3:0] b, input logic [4:0] r,
                            input bit clr_t5, input string tag);
      int cyc;
      bit got;
      @(negedge clk);
      check({tag, ".idle_rdy"},  in_ready,   1);
      check({tag, ".idle_done"}, done_valid, 0);
      x0 = a;
      x1 = b;
      o  = r;
      in_valid = 1'b1;
      @(posedge clk);
      cyc = 0;
      got = 1'b0;
      while (cyc < 12) begin
         @(negedge clk);
         if (done_valid) begin
            got = 1'b1;
            break;
         end
         check({tag, ".busy_rdy"}, in_ready, 0);
         in_valid = 1'($urandom_range(0, 1));
         x0 = 4'($urandom);
         x1 = 4'($urandom);
         o  = 5'($urandom);
         if (clr_t5 && cyc == 4) clr = 1'b1;
         @(posedge clk);
         cyc++;
      end
      clr      = 1'b0;
      in_valid = 1'b0;
      check({tag, ".done_seen"}, got, 1);
      check({tag, ".latency"},   cyc, 5);
      check({tag, ".match"},     match, sum_ok(a, b, r));
      model_done(a, b, r, clr_t5);
      check_counters(tag);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_clear();
      check_counters("clr");
   endtask

   initial begin
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] r;
      int         p;
      bit         idle;
      logic [3:0] sa;
      logic [3:0] sb;
      logic [4:0] so;

      rst      = 1'b1;
      in_valid = 1'b0;
      clr      = 1'b0;
      x0       = 4'd0;
      x1       = 4'd0;
      o        = 5'd0;
      model_clear();
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      rst = 1'b0;

      // Basic match, then the 15+15 carry-out case and a dropped carry.
      run_check(4'd3,  4'd5,  5'd8,  1'b0, "add3_5");
      run_check(4'd15, 4'd15, 5'd30, 1'b0, "add15_15");
      run_check(4'd15, 4'd15, 5'd14, 1'b0, "drop_carry");

      // Back-to-back mismatches: capture keeps the first.
      pulse_clr();
      run_check(4'd7, 4'd9, 5'd15, 1'b0, "mis7_9");
      run_check(4'd1, 4'd1, 5'd3,  1'b0, "mis1_1");

      // Random triples, about half of them correct.
      for (int i = 0; i < 40; i++) begin
         a = 4'($urandom);
         b = 4'($urandom);
         r = ($urandom_range(0, 1) == 1) ? 5'(int'(a) + int'(b)) : 5'($urandom);
         run_check(a, b, r, 1'b0, "rand");
      end

      // in_valid held high with operands changing every cycle. The model
      // tracks edges since the last accept (-1 = nothing in flight).
      p = -1;
      for (int i = 0; i < 75; i++) begin
         @(negedge clk);
         idle = (p < 0) || (p == 5);
         check("cont.in_ready",   in_ready,   idle);
         check("cont.done_valid", done_valid, (p == 5));
         if (p == 5) begin
            check("cont.match", match, sum_ok(sa, sb, so));
            model_done(sa, sb, so, 1'b0);
            check_counters("cont");
         end
         in_valid = (i < 65);
         a = 4'($urandom);
         b = 4'($urandom);
         x0 = a;
         x1 = b;
         o  = ($urandom_range(0, 1) == 1) ? 5'(int'(a) + int'(b)) : 5'($urandom);
         @(posedge clk);
         if (idle && in_valid) begin
            p  = 0;
            sa = x0;
            sb = x1;
            so = o;
         end else if (p >= 0 && p < 5) begin
            p++;
         end else begin
            p = -1;
         end
      end
      in_valid = 1'b0;

      // Reset two cycles into a check: discarded, all outputs cleared.
      @(negedge clk);
      x0 = 4'd3;
      x1 = 4'd4;
      o  = 5'd7;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("midrst.no_done", done_valid, 0);
      end
      // Prime a count so the clr at T5 has something visible to clear.
      run_check(4'd2, 4'd2, 5'd4, 1'b0, "pre_clr");
      run_check(4'd6, 4'd9, 5'd15, 1'b1, "clr_t5");

      // Saturation: exhaustive sweep plus 44 repeats, all matching.
      pulse_clr();
      for (int i = 0; i < 300; i++) begin
         if (i < 256) begin
            a = 4'(i >> 4);
            b = 4'(i);
         end else begin
            a = 4'($urandom);
            b = 4'($urandom);
         end
         run_check(a, b, 5'(int'(a) + int'(b)), 1'b0, "sat");
      end
      check("sat.final", pass_cnt, 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
